binary_add_sub_pipe: RTL and testbench
======================================

BINARY_ADD_SUB_PIPE -- requirements
Module: binary_add_sub_pipe

Interface
REQ-001 Parameter WIDTH, 16, operand/result width in bits; WIDTH >= 4.
REQ-002 Parameter SEG_W, 4, carry-segment width in bits; WIDTH % SEG_W == 0; NSEG = WIDTH/SEG_W pipeline stages.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 M  input  1  mode: 0 = A+B, 1 = A-B.
REQ-009 A, B  input  WIDTH each  unsigned/two's-complement operands.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 Sum  output  WIDTH  result.
REQ-013 Co  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 Ovf  output  1  signed two's-complement overflow.
REQ-015 Zero  output  1  Sum == 0.

Function
REQ-016 Subtract SHALL be A + ~B + 1, with carry-in = M; Co is the raw MSB carry in both modes.
REQ-017 Stage k (0..NSEG-1) SHALL compute bits [k*SEG_W +: SEG_W] using the carry registered from stage k-1 (stage 0 uses M).
REQ-018 Upper operand segments and M SHALL be skewed through registers so each stage sees its own beat's data; lower result segments SHALL be delayed to align at the output.
REQ-019 Latency SHALL be exactly NSEG cycles from accepted beat (in_valid & in_ready) to out_valid with no stall; throughput SHALL be one beat per cycle.
REQ-020 Ovf SHALL be carry-into-MSB XOR carry-out-of-MSB; Zero SHALL be computed on the full aligned Sum.
REQ-021 Stall rule: advance = ~out_valid | out_ready; when advance is 0, every stage register SHALL hold; in_ready = advance.
REQ-022 Each stage SHALL carry a valid bit; bubbles SHALL propagate without altering data order.
REQ-023 Sum/Co/Ovf/Zero SHALL be stable while out_valid & ~out_ready.
REQ-024 Beats SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-025 in_valid while in_ready = 0 SHALL NOT be captured; the source must hold the beat.
REQ-026 Simultaneous output pop and input push with a full pipeline SHALL both complete in the same cycle.

Reset
REQ-027 While rst_n = 0 at a clock edge, all stage valid bits, out_valid, Sum, Co, Ovf and Zero SHALL clear to 0; in_ready SHALL read 1 from the first cycle after reset.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight beat; no stale result appears after release.

Structure
REQ-029 A shared package binary_add_sub_pkg SHALL hold the mode enum (ADD=0, SUB=1) and the default WIDTH/SEG_W constants.
REQ-030 One sub-module add_seg (SEG_W-bit ripple slice: a, b, cin -> s, cout, carry into MSB) SHALL be instantiated NSEG times via generate.

Verification (WIDTH=16, SEG_W=4, latency 4)
REQ-031 M=0, A=0x00FF, B=0x0001 -> 4 cycles later Sum=0x0100, Co=0, Ovf=0, Zero=0.
REQ-032 M=1, A=0x0001, B=0x0005 -> Sum=0xFFFC, Co=0, Ovf=0; M=1, A=0x8000, B=0x0001 -> Sum=0x7FFF, Co=1, Ovf=1.
REQ-033 M=0, A=0x7FFF, B=0x0001 -> Sum=0x8000, Ovf=1, Co=0; M=0, A=0xFFFF, B=0x0001 -> Sum=0x0000, Co=1, Zero=1, Ovf=0.
REQ-034 Back-to-back 6 beats, out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during the stall, outputs held, all 6 results emerge in order with correct values.
REQ-035 rst_n=0 for 1 cycle while 3 beats are in flight -> out_valid stays 0 until a new beat is accepted, first result appears exactly 4 cycles after that acceptance.
REQ-036 Random A/B/M with random in_valid/out_ready (10k beats) -> every result matches the reference model (A±B, carry, signed overflow, zero) in order.

Source files
------------

// File: rtl/binary_add_sub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// binary_add_sub_pkg
// Shared definitions for the segmented add/subtract pipeline: the operation
// mode encoding, default operand and carry-segment widths, and a helper that
// derives the pipeline depth from them.
// Ports: none (package).
// ---------------------------------------------------------------------------
package binary_add_sub_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG_W = 4;

    // One pipeline stage per carry segment.
    function automatic int num_seg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/binary_add_sub_pipe_if.sv
// ---------------------------------------------------------------------------
// binary_add_sub_pipe_if
// Operand/result handshake bundle for binary_add_sub_pipe.
// Ports (signals):
//   in_valid / in_ready   operand beat handshake (source -> block)
//   M, A, B               mode (0 add, 1 subtract) and operands
//   out_valid / out_ready result beat handshake (block -> sink)
//   Sum, Co, Ovf, Zero    result, raw MSB carry, signed overflow, Sum == 0
// Modports: master = stimulus/consumer side, slave = the pipeline.
// ---------------------------------------------------------------------------
interface binary_add_sub_pipe_if
    import binary_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic             M;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Co;
    logic             Ovf;
    logic             Zero;

    modport master (
        output in_valid, M, A, B, out_ready,
        input  in_ready, out_valid, Sum, Co, Ovf, Zero
    );

    modport slave (
        input  in_valid, M, A, B, out_ready,
        output in_ready, out_valid, Sum, Co, Ovf, Zero
    );

endinterface

// File: rtl/binary_add_sub_pipe_add_seg.sv
// ---------------------------------------------------------------------------
// add_seg
// SEG_W-bit ripple-carry slice used by each pipeline stage.
// Ports:
//   a, b  in   SEG_W  slice operands (b already conditionally inverted)
//   cin   in   1      carry into bit 0
//   s     out  SEG_W  slice sum
//   cout  out  1      carry out of the slice MSB
//   cmsb  out  1      carry into the slice MSB (used for signed overflow)
// ---------------------------------------------------------------------------
module add_seg
    import binary_add_sub_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [SEG_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SEG_W];
    assign cmsb = c[SEG_W-1];

endmodule

// File: rtl/binary_add_sub_pipe.sv
// ---------------------------------------------------------------------------
// binary_add_sub_pipe
// Carry-segmented add/subtract pipeline. Stage k adds bits
// [k*SEG_W +: SEG_W] using the carry registered by stage k-1; the operand
// bits a stage has not reached yet travel alongside in skew registers, and the
// finished low result segments travel forward so the full word lines up at
// the last stage. Subtract is A + ~B + 1 (carry-in = M). Latency is NSEG
// cycles, one beat per cycle; the whole pipe stalls together when the output
// is held.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of binary_add_sub_pipe_if (handshake, operands,
//          result flags)
// ---------------------------------------------------------------------------
module binary_add_sub_pipe
    import binary_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binary_add_sub_pipe_if.slave  bus
);

    localparam int NSEG = num_seg(WIDTH, SEG_W);

    if (WIDTH < 4 || SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_param_err
        $error("binary_add_sub_pipe: WIDTH must be >= 4 and a multiple of SEG_W");
    end

    logic advance;
    logic last_v;

    for (genvar k = 0; k < NSEG; k++) begin : g_st
        localparam int RW = (k + 1) * SEG_W;

        logic [SEG_W-1:0] a_seg;
        logic [SEG_W-1:0] b_seg;
        logic [SEG_W-1:0] b_eff;
        logic [SEG_W-1:0] s_seg;
        logic             cin;
        logic             m_in;
        logic             v_in;
        logic             cout;
        logic             cmsb;
        logic             load;
        logic [RW-1:0]    r_new;

        logic             v_q, v_d;
        logic             c_q, c_d;
        logic [RW-1:0]    r_q, r_d;

        if (k == 0) begin : g_src
            assign a_seg = bus.A[SEG_W-1:0];
            assign b_seg = bus.B[SEG_W-1:0];
            assign cin   = bus.M;
            assign m_in  = bus.M;
            assign v_in  = bus.in_valid;
            assign r_new = s_seg;
        end else begin : g_src
            assign a_seg = g_st[k-1].g_skew.a_up_q[SEG_W-1:0];
            assign b_seg = g_st[k-1].g_skew.b_up_q[SEG_W-1:0];
            assign cin   = g_st[k-1].c_q;
            assign m_in  = g_st[k-1].g_skew.m_q;
            assign v_in  = g_st[k-1].v_q;
            assign r_new = {s_seg, g_st[k-1].r_q};
        end

        assign b_eff = (mode_e'(m_in) == SUB) ? ~b_seg : b_seg;

        add_seg #(
            .SEG_W (SEG_W)
        ) u_add_seg (
            .a    (a_seg),
            .b    (b_eff),
            .cin  (cin),
            .s    (s_seg),
            .cout (cout),
            .cmsb (cmsb)
        );

        // Data only moves with a real beat, so bubbles leave the last
        // result parked at the output instead of overwriting it.
        assign load = advance & v_in;

        always_comb begin
            v_d = v_q;
            c_d = c_q;
            r_d = r_q;
            if (advance) begin
                v_d = v_in;
            end
            if (load) begin
                c_d = cout;
                r_d = r_new;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else begin
                v_q <= v_d;
                c_q <= c_d;
                r_q <= r_d;
            end
        end

        // Operand bits above this stage's segment, plus the mode, ride along
        // so the next stage sees its own beat.
        if (k < NSEG - 1) begin : g_skew
            localparam int UW = WIDTH - RW;

            logic [UW-1:0] a_up_src;
            logic [UW-1:0] b_up_src;
            logic [UW-1:0] a_up_q, a_up_d;
            logic [UW-1:0] b_up_q, b_up_d;
            logic          m_q, m_d;

            if (k == 0) begin : g_up
                assign a_up_src = bus.A[WIDTH-1:SEG_W];
                assign b_up_src = bus.B[WIDTH-1:SEG_W];
            end else begin : g_up
                assign a_up_src = g_st[k-1].g_skew.a_up_q[UW+SEG_W-1:SEG_W];
                assign b_up_src = g_st[k-1].g_skew.b_up_q[UW+SEG_W-1:SEG_W];
            end

            always_comb begin
                a_up_d = a_up_q;
                b_up_d = b_up_q;
                m_d    = m_q;
                if (load) begin
                    a_up_d = a_up_src;
                    b_up_d = b_up_src;
                    m_d    = m_in;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                    m_q    <= 1'b0;
                end else begin
                    a_up_q <= a_up_d;
                    b_up_q <= b_up_d;
                    m_q    <= m_d;
                end
            end
        end
    end

    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (g_st[NSEG-1].load) begin
            ovf_d  = g_st[NSEG-1].cmsb ^ g_st[NSEG-1].cout;
            zero_d = (g_st[NSEG-1].r_new == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign last_v        = g_st[NSEG-1].v_q;
    assign advance       = ~last_v | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = last_v;
    assign bus.Sum       = g_st[NSEG-1].r_q;
    assign bus.Co        = g_st[NSEG-1].c_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_binary_add_sub_pipe.sv
module tb_binary_add_sub_pipe;
    import binary_add_sub_pkg::*;

    localparam int WIDTH  = 16;
    localparam int SEG_W  = 4;
    localparam int LAT    = 4;
    localparam int NBEATS = 10000;

    typedef struct packed {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        co;
        logic        ovf;
        logic        z;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    binary_add_sub_pipe_if #(.WIDTH(WIDTH)) bus ();

    binary_add_sub_pipe #(
        .WIDTH (WIDTH),
        .SEG_W (SEG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: full-width arithmetic, overflow from operand signs.
    function automatic vec_t model_calc(input logic m, input logic [15:0] a, input logic [15:0] b);
        vec_t        v;
        logic [16:0] full;
        if (m == 1'b0) full = {1'b0, a} + {1'b0, b};
        else           full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        v.m   = m;
        v.a   = a;
        v.b   = b;
        v.s   = full[15:0];
        v.co  = full[16];
        v.ovf = (m == 1'b0) ? ((a[15] == b[15]) && (full[15] != a[15]))
                            : ((a[15] != b[15]) && (full[15] != a[15]));
        v.z   = (full[15:0] == 16'h0000);
        return v;
    endfunction

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.M        = 1'b0;
        bus.A        = 16'h1234;
        bus.B        = 16'h4321;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({bus.out_valid, bus.Sum, bus.Co, bus.Ovf, bus.Zero} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sum=%h co=%b ovf=%b z=%b exp all 0",
                     bus.out_valid, bus.Sum, bus.Co, bus.Ovf, bus.Zero);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
        end
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (bus.out_valid === 1'b1) seen = 1'b1;
            end
            n_tests++;
            if (seen) begin
                n_fail++;
                $display("FAIL reset_no_stale: got out_valid=1 exp 0");
            end
        end
    endtask

    task automatic run_single(input vec_t v, input string name);
        int k;
        bit seen = 1'b0;
        bus.M         = v.m;
        bus.A         = v.a;
        bus.B         = v.b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b exp 1", name, bus.in_ready);
        end
        for (k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen || k != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles (seen=%0b) exp %0d", name, k, seen, LAT);
        end
        if (seen) begin
            n_tests++;
            if (bus.Sum !== v.s) begin
                n_fail++;
                $display("FAIL %s_sum: got %h exp %h", name, bus.Sum, v.s);
            end
            n_tests++;
            if (bus.Co !== v.co) begin
                n_fail++;
                $display("FAIL %s_co: got %b exp %b", name, bus.Co, v.co);
            end
            n_tests++;
            if (bus.Ovf !== v.ovf) begin
                n_fail++;
                $display("FAIL %s_ovf: got %b exp %b", name, bus.Ovf, v.ovf);
            end
            n_tests++;
            if (bus.Zero !== v.z) begin
                n_fail++;
                $display("FAIL %s_zero: got %b exp %b", name, bus.Zero, v.z);
            end
        end
        tick();
    endtask

    task automatic test_directed();
        vec_t v[$];
        //            m     a         b         sum       co    ovf   z
        v.push_back('{1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0});
        v.push_back('{1'b1, 16'h0001, 16'h0005, 16'hFFFC, 1'b0, 1'b0, 1'b0});
        v.push_back('{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0});
        v.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1});
        v.push_back('{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1});
        v.push_back('{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1});
        foreach (v[i]) run_single(v[i], $sformatf("vec%0d", i));
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        int   pushed = 0;
        int   popped = 0;
        int   stall_left = -1;
        bit   acc;
        bit   pop;
        v.push_back('{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0});
        v.push_back('{1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0});
        v.push_back('{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0});
        v.push_back('{1'b0, 16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b1, 1'b0});
        v.push_back('{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1});
        for (int cyc = 0; cyc < 60 && popped < 6; cyc++) begin
            if (stall_left < 0 && bus.out_valid === 1'b1) stall_left = 3;
            bus.out_ready = !(stall_left > 0);
            if (pushed < 6) begin
                bus.in_valid = 1'b1;
                bus.M        = v[pushed].m;
                bus.A        = v[pushed].a;
                bus.B        = v[pushed].b;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                n_tests++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_stall_in_ready: got %b exp 0", bus.in_ready);
                end
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.Sum !== v[popped].s || bus.Co !== v[popped].co) begin
                    n_fail++;
                    $display("FAIL b2b_stall_hold: got valid=%b sum=%h co=%b exp valid=1 sum=%h co=%b",
                             bus.out_valid, bus.Sum, bus.Co, v[popped].s, v[popped].co);
                end
            end
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            pop = (bus.out_valid === 1'b1) && bus.out_ready;
            if (pop) begin
                n_tests++;
                if ({bus.Sum, bus.Co, bus.Ovf, bus.Zero} !== {v[popped].s, v[popped].co, v[popped].ovf, v[popped].z}) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got sum=%h co=%b ovf=%b z=%b exp sum=%h co=%b ovf=%b z=%b",
                             popped, bus.Sum, bus.Co, bus.Ovf, bus.Zero,
                             v[popped].s, v[popped].co, v[popped].ovf, v[popped].z);
                end
                popped++;
            end
            if (acc) pushed++;
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
        end
        n_tests++;
        if (popped != 6 || stall_left != 0) begin
            n_fail++;
            $display("FAIL b2b_complete: got %0d results (stall_left=%0d) exp 6 (0)", popped, stall_left);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit   seen = 1'b0;
        vec_t nv;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.M        = 1'b0;
            bus.A        = 16'(16'h0101 * (i + 1));
            bus.B        = 16'h0001;
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.out_valid, bus.Sum, bus.Co, bus.Ovf, bus.Zero} !== 20'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: got valid=%b sum=%h co=%b ovf=%b z=%b exp all 0",
                     bus.out_valid, bus.Sum, bus.Co, bus.Ovf, bus.Zero);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midrst_stale: got out_valid=1 exp 0");
        end
        nv = '{1'b1, 16'h0300, 16'h0001, 16'h02FF, 1'b1, 1'b0, 1'b0};
        run_single(nv, "midrst_new");
    endtask

    task automatic test_random();
        vec_t        q[$];
        vec_t        e;
        int          sent = 0;
        int          got  = 0;
        bit          have = 1'b0;
        logic [15:0] ca = '0;
        logic [15:0] cb = '0;
        logic        cm = 1'b0;
        for (int cyc = 0; cyc < 60000 && got < NBEATS; cyc++) begin
            if (!have && sent < NBEATS && $urandom_range(3) != 0) begin
                ca   = 16'($urandom);
                cb   = 16'($urandom);
                cm   = 1'($urandom_range(1));
                have = 1'b1;
            end
            bus.in_valid  = have;
            bus.M         = cm;
            bus.A         = ca;
            bus.B         = cb;
            bus.out_ready = ($urandom_range(3) != 0);
            #1;
            if (bus.out_valid === 1'b1) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got out_valid=1 exp no pending beat");
                end else begin
                    e = q[0];
                    if ({bus.Sum, bus.Co, bus.Ovf, bus.Zero} !== {e.s, e.co, e.ovf, e.z}) begin
                        n_fail++;
                        $display("FAIL rand_beat%0d: m=%b a=%h b=%h got sum=%h co=%b ovf=%b z=%b exp sum=%h co=%b ovf=%b z=%b",
                                 got, e.m, e.a, e.b, bus.Sum, bus.Co, bus.Ovf, bus.Zero,
                                 e.s, e.co, e.ovf, e.z);
                    end
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (have && bus.in_ready === 1'b1) begin
                q.push_back(model_calc(cm, ca, cb));
                have = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (got != NBEATS) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results exp %0d", got, NBEATS);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.M         = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
